conv1_psum_accum: RTL
=====================

# conv1_psum_accum

Channel-wise partial-sum accumulator sitting directly downstream of the PE array's MAC chain. Each 3x3 tap chain emits one signed partial sum per output pixel per input channel. This block sums those partial sums over all input channels in a per-pixel buffer, then adds the output-channel bias and streams one finished pre-activation value per pixel to the spiking/neuron stage.

## Interface
- PSUM_W, 20, width of incoming signed partial sum (MAC chain output width)
- ACC_W, 24, width of accumulator and output; must be >= PSUM_W + clog2(CH_NUM) + 1
- BIAS_W, 16, width of signed bias
- PIX_NUM, 32, output pixels per pass (buffer depth); must be >= 2
- CH_NUM, 3, input channels accumulated per pass; must be >= 1
- s_clk  in  1  clock; all logic on rising edge
- s_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle pulse: begin a pass, latch i_bias
- i_bias  in  BIAS_W  signed bias, sampled only when i_start=1
- i_psum_valid  in  1  partial sum present this cycle
- i_psum_data  in  PSUM_W  signed partial sum
- o_acc_valid  out  1  finished pixel value present
- o_acc_data  out  ACC_W  signed sum over channels plus bias
- o_acc_last  out  1  with o_acc_valid: last pixel of the pass
- o_busy  out  1  high from the cycle after i_start until the pass is done
- o_done  out  1  one-cycle pulse when the pass completes
- o_overrun  out  1  sticky error: i_psum_valid seen while IDLE; cleared only by s_rst or i_start

## Operation
- FSM states: IDLE, RUN, DONE. Reset state: IDLE.
- IDLE -> RUN on i_start. Actions on that edge:
  - bias latched, sign-extended to ACC_W
  - pix_cnt and ch_cnt cleared to 0
  - o_overrun cleared
- i_start in RUN or DONE is ignored.
- RUN: each i_psum_valid consumes one beat in pixel-major order within a channel: pixel 0..PIX_NUM-1 of channel 0, then the same for channel 1, and so on. No backpressure; a valid may arrive every cycle and gaps are allowed.
  - pix_cnt increments per beat and wraps to 0 after PIX_NUM-1. ch_cnt increments on that wrap.
- Per-beat arithmetic, with psum sign-extended to ACC_W:
  - ch_cnt == 0: write psum to buf[pix] (old buffer content ignored)
  - 0 < ch_cnt < CH_NUM-1: buf[pix] <= buf[pix] + psum
  - ch_cnt == CH_NUM-1: output buf[pix] + psum + bias; the buffer write is don't-care
  - CH_NUM == 1: first channel is also last, so output psum + bias
- Overflow wraps two's complement at ACC_W. There is no saturation.
- The beat at pix=PIX_NUM-1 of the last channel outputs with o_acc_last=1. On the edge that registers that output, the FSM goes RUN -> DONE.
- DONE lasts one cycle with o_done=1, then the FSM goes to IDLE. i_psum_valid during DONE is dropped and sets o_overrun.
- i_psum_valid in IDLE: beat dropped, o_overrun <= 1.
- Buffer: PIX_NUM x ACC_W simple dual-port RAM with synchronous read (1-cycle). It is not cleared by reset, because channel 0 always overwrites.
- s_rst mid-pass aborts the pass:
  - state to IDLE, counters to 0
  - all outputs 0
  - pipeline valids flushed
  - no partial output is emitted

## Timing
- Reset values: o_acc_valid=0, o_acc_data=0, o_acc_last=0, o_busy=0, o_done=0, o_overrun=0.
- Beat accepted at edge t:
  - RAM read of buf[pix] issued; psum and flags registered
  - edge t+1: sum computed, RAM write performed, o_acc_* registered
  - latency from input beat to o_acc_valid is 2 cycles
- Read-after-write hazard: the same address recurs no sooner than PIX_NUM cycles later. PIX_NUM >= 2 guarantees the write lands before the next read, so no bypass is needed.
- o_busy rises the cycle after i_start and falls when o_done asserts.
- o_done asserts the cycle after o_acc_last.
- Full-rate throughput: one beat per cycle. The first output appears (CH_NUM-1)*PIX_NUM + 2 cycles after the first beat.

## Test plan
- Basic pass, PIX_NUM=4, CH_NUM=3, bias=10, psum for every beat = pix+1:
  - outputs 13,16,19,22 in that order
  - o_acc_last only on 22
  - o_done pulses once, one cycle after 22
- Signed extremes, PSUM_W=20, CH_NUM=3, bias=-32768:
  - all psums = -524288 -> each output = -1605632
  - all psums = 524287 -> each output = 1540093
- Bubbles: same stimulus as basic pass but valid toggled every other cycle -> identical output values, each 2 cycles after its final-channel beat.
- CH_NUM=1, bias=-5, psums 5,6,7,8 -> outputs 0,1,2,3, each 2 cycles after its input.
- Overrun: i_psum_valid while IDLE -> o_overrun=1, no output. A following i_start clears it, and a clean pass then matches the basic pass.
- Reset mid-pass, asserted after 6 beats of the basic pass:
  - all outputs 0 immediately (asynchronous)
  - a fresh pass afterwards gives 13,16,19,22, with no stale buffer data visible

Source files
------------

// File: rtl/conv1_psum_accum_if.sv
// Stream bundle between the PE MAC chain, the channel accumulator and the
// neuron stage. The master side drives the pass control and the partial-sum
// stream. The slave side is the accumulator, which returns the finished
// pixel stream and the status flags.
interface conv1_psum_accum_if #(
  parameter int PSUM_W = 20,
  parameter int ACC_W  = 24,
  parameter int BIAS_W = 16
);
  logic              i_start;
  logic [BIAS_W-1:0] i_bias;
  logic              i_psum_valid;
  logic [PSUM_W-1:0] i_psum_data;
  logic              o_acc_valid;
  logic [ACC_W-1:0]  o_acc_data;
  logic              o_acc_last;
  logic              o_busy;
  logic              o_done;
  logic              o_overrun;

  modport master (
    output i_start, i_bias, i_psum_valid, i_psum_data,
    input  o_acc_valid, o_acc_data, o_acc_last, o_busy, o_done, o_overrun
  );

  modport slave (
    input  i_start, i_bias, i_psum_valid, i_psum_data,
    output o_acc_valid, o_acc_data, o_acc_last, o_busy, o_done, o_overrun
  );
endinterface

// File: rtl/conv1_psum_accum.sv
// Channel-wise partial-sum accumulator. Partial sums arrive pixel-major
// within each input channel. They are summed per pixel in a sync-read buffer.
// On the final channel the bias is added and the value is streamed out.
//
// state | meaning
// IDLE  | waiting for i_start; stray beats are dropped and flag overrun
// RUN   | consuming beats; leaves when the last pixel's output is registered
// DONE  | single cycle; o_done pulses on the following edge, then IDLE
module conv1_psum_accum #(
  parameter int PSUM_W  = 20,
  parameter int ACC_W   = 24,
  parameter int BIAS_W  = 16,
  parameter int PIX_NUM = 32,
  parameter int CH_NUM  = 3
) (
  input  logic             s_clk,
  input  logic             s_rst,
  conv1_psum_accum_if.slave bus
);
  localparam int PIX_W = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_NUM - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_NUM - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t state, state_nxt;

  logic [PIX_W-1:0] pix_cnt;
  logic [CH_W-1:0]  ch_cnt;
  logic             in_done;   // every beat of the pass already consumed
  logic [ACC_W-1:0] bias_q;

  logic             s1_valid;
  logic             s1_first;
  logic             s1_last_ch;
  logic             s1_last_pix;
  logic [PIX_W-1:0] s1_pix;
  logic [ACC_W-1:0] s1_psum;

  logic [ACC_W-1:0] mem [PIX_NUM];
  logic [ACC_W-1:0] rd_data;

  logic             start_ok;
  logic             beat;
  logic             fin;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] out_val;

  assign start_ok = (state == ST_IDLE) && bus.i_start;
  assign beat     = (state == ST_RUN) && bus.i_psum_valid && !in_done;
  assign fin      = s1_valid && s1_last_ch && s1_last_pix;

  // Channel 0 ignores the buffer, so the RAM never needs clearing.
  assign base    = s1_first ? '0 : rd_data;
  assign sum     = base + s1_psum;
  assign out_val = sum + bias_q;

  // State register.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.i_start) state_nxt = ST_RUN;
      ST_RUN:  if (fin)         state_nxt = ST_DONE;
      ST_DONE:                  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Beat counters and the bias latch.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      pix_cnt <= '0;
      ch_cnt  <= '0;
      in_done <= 1'b0;
      bias_q  <= '0;
    end else if (start_ok) begin
      pix_cnt <= '0;
      ch_cnt  <= '0;
      in_done <= 1'b0;
      bias_q  <= {{(ACC_W-BIAS_W){bus.i_bias[BIAS_W-1]}}, bus.i_bias};
    end else if (beat) begin
      if (pix_cnt == PIX_LAST) begin
        pix_cnt <= '0;
        if (ch_cnt == CH_LAST) begin
          ch_cnt  <= '0;
          in_done <= 1'b1;
        end else begin
          ch_cnt <= ch_cnt + CH_W'(1);
        end
      end else begin
        pix_cnt <= pix_cnt + PIX_W'(1);
      end
    end
  end

  // Stage 1: register the beat and its position flags alongside the RAM read.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s1_last_ch  <= 1'b0;
      s1_last_pix <= 1'b0;
      s1_pix      <= '0;
      s1_psum     <= '0;
    end else begin
      s1_valid <= beat;
      if (beat) begin
        s1_first    <= (ch_cnt == '0);
        s1_last_ch  <= (ch_cnt == CH_LAST);
        s1_last_pix <= (pix_cnt == PIX_LAST);
        s1_pix      <= pix_cnt;
        s1_psum     <= {{(ACC_W-PSUM_W){bus.i_psum_data[PSUM_W-1]}}, bus.i_psum_data};
      end
    end
  end

  // Per-pixel buffer. The read-modify-write of a pixel completes within two
  // cycles, and the same pixel returns at least PIX_NUM cycles later, so no bypass.
  always_ff @(posedge s_clk) begin
    if (beat)     rd_data     <= mem[pix_cnt];
    if (s1_valid) mem[s1_pix] <= sum;
  end

  // Output stream and status flags.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      bus.o_acc_valid <= 1'b0;
      bus.o_acc_data  <= '0;
      bus.o_acc_last  <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_overrun   <= 1'b0;
    end else begin
      bus.o_acc_valid <= s1_valid && s1_last_ch;
      bus.o_acc_last  <= fin;
      if (s1_valid && s1_last_ch) bus.o_acc_data <= out_val;
      bus.o_done <= (state == ST_DONE);
      if (start_ok)                bus.o_busy <= 1'b1;
      else if (state == ST_DONE)   bus.o_busy <= 1'b0;
      if (start_ok)
        bus.o_overrun <= 1'b0;
      else if (bus.i_psum_valid && ((state != ST_RUN) || in_done))
        bus.o_overrun <= 1'b1;
    end
  end
endmodule
